fir_tap_loader: RTL and testbench

Run-time coefficient controller for the adjustable-tap `genericfir` datapath (FIXED_TAPS=0). It accepts a full coefficient set over a valid/ready stream into a shadow buffer while the filter keeps running. On completion it stalls the sample flow, shifts the set into the filter's tap chain, then masks the outputs that were computed with mixed or stale taps. It sits between the sample source, the coefficient source and the filter instance.

---
 rtl/fir_tap_loader_pkg.sv | 27 ++
 rtl/fir_tap_loader_shadow.sv | 29 ++
 rtl/fir_tap_loader.sv | 133 +++++++++++++
 tb/tb_fir_tap_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_loader_pkg.sv
// Shared definitions for the run-time FIR coefficient loader.
package fir_tap_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width that is never zero, so single-entry arrays still get a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_loader_shadow.sv
// Shadow coefficient store: one write port, one asynchronous read port.
// Data is intentionally not reset; only complete sets are ever shifted out.
module fir_coef_shadow
    import fir_tap_loader_pkg::*;
#(
    parameter int unsigned NTAPS = 128,
    parameter int unsigned TW    = 12,
    parameter int unsigned AW    = 7
) (
    input  logic          i_clk,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic [TW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [TW-1:0] o_rdata
);

    logic [TW-1:0] mem [NTAPS];

    // Capture each accepted coefficient word at its index.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fir_tap_loader.sv
// Run-time coefficient controller for an adjustable-tap FIR: buffers a full
// coefficient set, stalls samples while shifting it into the tap chain, then
// masks results computed with mixed or stale taps.
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int unsigned NTAPS = 128,
    parameter int unsigned TW    = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_coef_valid,
    output logic          o_coef_ready,
    input  logic [TW-1:0] i_coef,
    input  logic          i_coef_last,
    output logic          o_load_err,
    output logic          o_load_done,
    input  logic          i_sample_valid,
    output logic          o_sample_ready,
    output logic          o_fir_ce,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_result_valid
);

    localparam int unsigned AW = idx_width(NTAPS);
    localparam int unsigned MW = clog2(NTAPS + 2);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NTAPS - 1);
    localparam logic [MW-1:0] MASK_INIT = MW'(NTAPS + 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] sidx;
    logic [MW-1:0] mask_cnt;
    logic          coef_acc;
    logic [TW-1:0] shadow_rdata;

    assign coef_acc = i_coef_valid & o_coef_ready;
    assign o_fir_ce = i_sample_valid & o_sample_ready;
    assign o_tap    = o_tap_wr ? shadow_rdata : '0;

    fir_coef_shadow #(
        .NTAPS (NTAPS),
        .TW    (TW),
        .AW    (AW)
    ) u_shadow (
        .i_clk   (i_clk),
        .i_wr    (coef_acc),
        .i_waddr (ptr),
        .i_wdata (i_coef),
        .i_raddr (sidx),
        .o_rdata (shadow_rdata)
    );

    // Load/shift sequencing, warm-up mask and all registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            sidx           <= '0;
            mask_cnt       <= MASK_INIT;
            o_coef_ready   <= 1'b0;
            o_sample_ready <= 1'b0;
            o_tap_wr       <= 1'b0;
            o_load_done    <= 1'b0;
            o_load_err     <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            o_load_err     <= 1'b0;
            o_load_done    <= 1'b0;
            o_result_valid <= o_fir_ce & (mask_cnt == '0);
            if (o_fir_ce && (mask_cnt != '0)) begin
                mask_cnt <= mask_cnt - 1'b1;
            end

            case (state)
                // IDLE and LOAD share one branch: ptr is always 0 in IDLE, so
                // the first word of a set follows the same length rules.
                ST_IDLE, ST_LOAD: begin
                    o_coef_ready   <= 1'b1;
                    o_sample_ready <= 1'b1;
                    o_tap_wr       <= 1'b0;
                    if (coef_acc) begin
                        if (ptr == LAST_IDX) begin
                            ptr <= '0;
                            if (i_coef_last) begin
                                state          <= ST_SHIFT;
                                sidx           <= '0;
                                mask_cnt       <= MASK_INIT;
                                o_coef_ready   <= 1'b0;
                                o_sample_ready <= 1'b0;
                                o_tap_wr       <= 1'b1;
                                o_load_done    <= (NTAPS == 1);
                            end else begin
                                state      <= ST_IDLE;
                                o_load_err <= 1'b1;
                            end
                        end else if (i_coef_last) begin
                            ptr        <= '0;
                            state      <= ST_IDLE;
                            o_load_err <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (sidx == LAST_IDX) begin
                        state          <= ST_IDLE;
                        sidx           <= '0;
                        o_tap_wr       <= 1'b0;
                        o_coef_ready   <= 1'b1;
                        o_sample_ready <= 1'b1;
                    end else begin
                        sidx        <= sidx + 1'b1;
                        o_load_done <= ((sidx + 1'b1) == LAST_IDX);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    ptr      <= '0;
                    sidx     <= '0;
                    o_tap_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader with NTAPS=4, TW=12. A queue-based
// reference model predicts every output each cycle; a small behavioural
// filter model consumes o_tap/o_tap_wr/o_fir_ce to check the impulse response.
module tb_fir_tap_loader;

    localparam int NTAPS = 4;
    localparam int TW    = 12;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_coef_valid;
    logic          o_coef_ready;
    logic [TW-1:0] i_coef;
    logic          i_coef_last;
    logic          o_load_err;
    logic          o_load_done;
    logic          i_sample_valid;
    logic          o_sample_ready;
    logic          o_fir_ce;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;
    logic          o_result_valid;
    logic [TW-1:0] smp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_tap_loader #(
        .NTAPS (NTAPS),
        .TW    (TW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_coef_valid   (i_coef_valid),
        .o_coef_ready   (o_coef_ready),
        .i_coef         (i_coef),
        .i_coef_last    (i_coef_last),
        .o_load_err     (o_load_err),
        .o_load_done    (o_load_done),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_fir_ce       (o_fir_ce),
        .o_tap_wr       (o_tap_wr),
        .o_tap          (o_tap),
        .o_result_valid (o_result_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit        mdl_live = 1'b0;
    bit        m_cready, m_sready, m_tapwr, m_done, m_err, m_rv;
    int        m_tap;
    int        m_mask;
    int        m_words[$];
    int        m_shift[$];
    bit        m_ce, m_acc;

    // behavioural filter: taps[k] multiplies the sample k steps old
    int        f_taps[$] = '{0, 0, 0, 0};
    int        f_hist[$] = '{0, 0, 0, 0};
    int        filt_result = 0;
    int        resp_q[$];

    always @(negedge clk) begin
        if (mdl_live) begin
            chk("coef_ready", o_coef_ready, m_cready);
            chk("sample_ready", o_sample_ready, m_sready);
            chk("tap_wr", o_tap_wr, m_tapwr);
            chk("tap", o_tap, m_tap);
            chk("load_done", o_load_done, m_done);
            chk("load_err", o_load_err, m_err);
            chk("result_valid", o_result_valid, m_rv);
            chk("fir_ce", o_fir_ce, i_sample_valid & m_sready);
            chk("ce_in_shift", o_fir_ce & o_tap_wr, 0);
            if (o_result_valid && resp_q.size() > 0) begin
                chk("impulse_resp", filt_result, resp_q.pop_front());
            end
        end

        // filter model follows what the DUT actually drives
        if (o_tap_wr === 1'b1) begin
            f_taps.push_back(int'(o_tap));
            void'(f_taps.pop_front());
        end
        if (o_fir_ce === 1'b1) begin
            f_hist.push_front(int'(smp));
            void'(f_hist.pop_back());
            filt_result = 0;
            for (int k = 0; k < NTAPS; k++) filt_result += f_taps[k] * f_hist[k];
        end

        // advance control model across the coming edge
        if (i_reset) begin
            mdl_live = 1'b1;
            m_cready = 0; m_sready = 0; m_tapwr = 0; m_tap = 0;
            m_done = 0; m_err = 0; m_rv = 0;
            m_mask = NTAPS + 1;
            m_words.delete();
            m_shift.delete();
        end else if (mdl_live) begin
            m_ce = i_sample_valid && m_sready;
            m_rv = m_ce && (m_mask == 0);
            if (m_ce && m_mask > 0) m_mask--;
            m_done = 0;
            m_err  = 0;
            if (m_shift.size() > 0) begin
                void'(m_shift.pop_front());
                if (m_shift.size() == 0) begin
                    m_tapwr = 0; m_tap = 0; m_cready = 1; m_sready = 1;
                end else begin
                    m_tap  = m_shift[0];
                    m_done = (m_shift.size() == 1);
                end
            end else begin
                m_acc = i_coef_valid && m_cready;
                m_cready = 1; m_sready = 1; m_tapwr = 0; m_tap = 0;
                if (m_acc) begin
                    m_words.push_back(int'(i_coef));
                    if (i_coef_last && m_words.size() == NTAPS) begin
                        m_shift = m_words;
                        m_words.delete();
                        m_mask  = NTAPS + 1;
                        m_tapwr = 1;
                        m_tap   = m_shift[0];
                        m_done  = (m_shift.size() == 1);
                        m_cready = 0;
                        m_sready = 0;
                    end else if (i_coef_last || m_words.size() == NTAPS) begin
                        m_err = 1;
                        m_words.delete();
                    end
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          cv;
        bit          last;
        logic [11:0] coef;
        bit          sv;
        bit          e_cr;
        bit          e_sr;
        bit          e_tw;
        logic [11:0] e_tap;
        bit          e_done;
        bit          e_err;
        bit          e_ce;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    function automatic vec_t mk(bit cv, bit last, int coef, bit sv, bit cr, bit sr,
                                bit tw, int tap, bit done, bit err, bit ce);
        vec_t v;
        v.cv = cv; v.last = last; v.coef = 12'(coef); v.sv = sv;
        v.e_cr = cr; v.e_sr = sr; v.e_tw = tw; v.e_tap = 12'(tap);
        v.e_done = done; v.e_err = err; v.e_ce = ce;
        return v;
    endfunction

    // ---------------- random coefficient source ----------------
    typedef struct {
        logic [11:0] w;
        bit          last;
    } cw_t;

    cw_t src_q[$];
    int  pushed   = 0;
    int  accepted = 0;

    function automatic void gen_set();
        int  len;
        cw_t c;
        len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, NTAPS + 1)) : NTAPS;
        for (int k = 0; k < len; k++) begin
            c.w    = 12'($urandom_range(0, 4095));
            c.last = (k == len - 1);
            src_q.push_back(c);
            pushed++;
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bit hs;
        bit seen_done;

        i_reset = 1'b1; i_coef_valid = 1'b0; i_coef = '0; i_coef_last = 1'b0;
        i_sample_valid = 1'b0; smp = '0;

        tbl[0]  = mk(1, 0, 1,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 0, 2,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 3,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 1, 4,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0,  1, 0, 0, 1, 2, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0,  1, 0, 0, 1, 3, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0,  1, 0, 0, 1, 4, 1, 0, 0);
        tbl[8]  = mk(1, 0, 5,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 6,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, 7,  1, 1, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 10, 1, 1, 1, 0, 0, 0, 1, 1);
        tbl[12] = mk(1, 0, 11, 1, 1, 1, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 0, 12, 1, 1, 1, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 13, 1, 1, 1, 0, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0,  1, 1, 1, 0, 0, 0, 1, 1);
        tbl[16] = mk(1, 1, 20, 1, 1, 1, 0, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0,  1, 1, 1, 0, 0, 0, 1, 1);
        tbl[18] = mk(0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 1);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_coef_ready", o_coef_ready, 0);
        chk("rst_sample_ready", o_sample_ready, 0);
        chk("rst_tap_wr", o_tap_wr, 0);
        chk("rst_tap", o_tap, 0);
        chk("rst_done", o_load_done, 0);
        chk("rst_err", o_load_err, 0);
        chk("rst_result_valid", o_result_valid, 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_coef_ready", o_coef_ready, 0);

        // table: good load, short set, long set, single-word set
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            i_coef_valid   = tbl[i].cv;
            i_coef_last    = tbl[i].last;
            i_coef         = tbl[i].coef;
            i_sample_valid = tbl[i].sv;
            smp            = 12'(i);
            @(negedge clk);
            chk($sformatf("v%0d.coef_ready", i), o_coef_ready, tbl[i].e_cr);
            chk($sformatf("v%0d.sample_ready", i), o_sample_ready, tbl[i].e_sr);
            chk($sformatf("v%0d.tap_wr", i), o_tap_wr, tbl[i].e_tw);
            chk($sformatf("v%0d.tap", i), o_tap, tbl[i].e_tap);
            chk($sformatf("v%0d.done", i), o_load_done, tbl[i].e_done);
            chk($sformatf("v%0d.err", i), o_load_err, tbl[i].e_err);
            chk($sformatf("v%0d.fir_ce", i), o_fir_ce, tbl[i].e_ce);
        end

        // load 1..4, then impulse after warm-up: 5 masked results, then h[k]
        @(posedge clk); #1;
        i_sample_valid = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = 12'(k + 1);
            i_coef_last  = (k == NTAPS - 1);
            @(posedge clk); #1;
        end
        i_coef_valid = 1'b0; i_coef_last = 1'b0;
        for (int c = 0; c < 20 && o_sample_ready !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        chk("shift_exit_sample_ready", o_sample_ready, 1);
        resp_q = '{1, 2, 3, 4, 0};
        for (int k = 1; k <= 11; k++) begin
            i_sample_valid = 1'b1;
            smp            = (k == 6) ? 12'd1 : 12'd0;
            @(negedge clk);
            if (k >= 2) chk($sformatf("warmup_rv_ce%0d", k - 1), o_result_valid, (k - 1) > 5);
            @(posedge clk); #1;
        end
        chk("impulse_all_seen", resp_q.size(), 0);
        i_sample_valid = 1'b0;

        // reset during the second SHIFT cycle
        for (int k = 0; k < NTAPS; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = 12'(12'h0A0 + k);
            i_coef_last  = (k == NTAPS - 1);
            @(posedge clk); #1;
        end
        i_coef_valid = 1'b0; i_coef_last = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        chk("rst_shift_tap_wr_before", o_tap_wr, 1);
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_shift_tap_wr_after", o_tap_wr, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            i_sample_valid = 1'b1;
            smp = 12'($urandom_range(0, 4095));
            @(negedge clk);
            seen_done |= o_load_done;
        end
        chk("rst_shift_no_done", seen_done, 0);

        // random gaps on both streams, some malformed sets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (src_q.size() == 0 && cyc < 2600) gen_set();
            i_coef_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (src_q.size() > 0) begin
                i_coef      = src_q[0].w;
                i_coef_last = src_q[0].last;
            end else begin
                i_coef      = '0;
                i_coef_last = 1'b0;
            end
            i_sample_valid = 1'($urandom_range(0, 1));
            smp = 12'($urandom_range(0, 4095));
            @(negedge clk);
            hs = i_coef_valid && o_coef_ready;
            @(posedge clk); #1;
            if (hs) begin
                void'(src_q.pop_front());
                accepted++;
            end
        end
        chk("src_drained", src_q.size(), 0);
        chk("words_accepted_once", accepted, pushed);

        i_coef_valid = 1'b0; i_sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
